// File: rtl/esn_readout_if.sv
// esn_readout_if
// Handshake bundle between the reservoir state registers (master) and the
// readout stage (slave).
//   in_valid / in_ready / xstate : state vector input, valid/ready
//   out_valid / out_ready / y    : readout sample output, valid/ready
//   sat_flag                     : y was clamped (qualified by out_valid)
//   overrun                      : sticky, a vector arrived while busy
interface esn_readout_if #(
  parameter int W = 16,
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] xstate;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   y;
  logic           sat_flag;
  logic           overrun;

  modport master (
    output in_valid, xstate, out_ready,
    input  in_ready, out_valid, y, sat_flag, overrun
  );

  modport slave (
    input  in_valid, xstate, out_ready,
    output in_ready, out_valid, y, sat_flag, overrun
  );
endinterface

// File: rtl/esn_readout.sv
// esn_readout
// Readout stage of the echo-state reservoir: y = BIAS + sum_k WOUT[k]*x[k],
// evaluated with one serial MAC (one term per cycle), then rounded half
// toward +inf and saturated to a W-bit fixed-point sample.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : esn_readout_if.slave (state vector in, readout sample out)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | in_ready high, waiting for a state vector
// S_MAC   | accumulating term idx, N cycles
// S_ROUND | round/saturate accumulator into y, raise out_valid
// S_OUT   | hold y until out_ready is sampled
module esn_readout #(
  parameter int             W    = 16,
  parameter int             N    = 8,
  parameter int             FRAC = 14,
  parameter int             ACCW = 40,
  parameter logic [N*W-1:0] WOUT = '0,
  parameter logic [W-1:0]   BIAS = '0
) (
  input  logic         clk,
  input  logic         rst,
  esn_readout_if.slave bus
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  // Bias moved into the accumulator's fractional alignment (state * weight).
  localparam logic signed [ACCW-1:0] ACC_INIT =
    $signed({{(ACCW-W){BIAS[W-1]}}, BIAS}) <<< FRAC;
  localparam logic signed [ACCW-1:0] RND =
    {{(ACCW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACCW-1:0] R_MAX =
    {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACCW-1:0] R_MIN =
    {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [IDXW-1:0]        idx;
  logic [N*W-1:0]         x_reg;
  logic signed [ACCW-1:0] acc;
  logic signed [W-1:0]    x_sel;
  logic signed [W-1:0]    w_sel;
  logic signed [2*W-1:0]  prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] rsum;
  logic signed [ACCW-1:0] r;
  logic                   sat_pos;
  logic                   sat_neg;
  logic [W-1:0]           y_rnd;
  logic [W-1:0]           y_reg;
  logic                   sat_reg;
  logic                   out_valid_reg;
  logic                   overrun_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid)    state_nxt = S_MAC;
      S_MAC:   if (idx == IDX_LAST) state_nxt = S_ROUND;
      S_ROUND:                      state_nxt = S_OUT;
      S_OUT:   if (bus.out_ready)   state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  // Operand select for the current term
  always_comb begin
    x_sel = '0;
    w_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDXW'(k)) begin
        x_sel = x_reg[k*W +: W];
        w_sel = WOUT[k*W +: W];
      end
    end
  end

  // Full signed 2W-bit product, sign-extended into the accumulator.
  assign prod     = x_sel * w_sel;
  assign prod_ext = {{(ACCW-2*W){prod[2*W-1]}}, prod};

  // Round half toward +inf, then clamp to the W-bit signed range.
  assign rsum    = acc + RND;
  assign r       = rsum >>> FRAC;
  assign sat_pos = (r > R_MAX);
  assign sat_neg = (r < R_MIN);

  always_comb begin
    y_rnd = r[W-1:0];
    if (sat_pos)      y_rnd = {1'b0, {(W-1){1'b1}}};
    else if (sat_neg) y_rnd = {1'b1, {(W-1){1'b0}}};
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      x_reg         <= '0;
      acc           <= '0;
      y_reg         <= '0;
      sat_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (bus.in_valid && (state != S_IDLE)) overrun_reg <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_reg <= bus.xstate;
            acc   <= ACC_INIT;
            idx   <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          idx <= idx + 1'b1;
        end
        S_ROUND: begin
          y_reg         <= y_rnd;
          sat_reg       <= sat_pos | sat_neg;
          out_valid_reg <= 1'b1;
        end
        S_OUT: begin
          if (bus.out_ready) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.y         = y_reg;
  assign bus.sat_flag  = sat_reg;
  assign bus.overrun   = overrun_reg;

endmodule
